axi4_ram_slave: RTL and testbench
=================================

# axi4_ram_slave

Parametrised AXI4 slave RAM that replaces the vendor BRAM IP behind `uart2axi4`. It adds configurable data width, depth and ID width, honours `wstrb`, and supports FIXED, INCR and WRAP bursts. Write and read channels run independently, and out-of-range or illegal requests return SLVERR instead of wrapping silently.

## Interface
- `BYTE_WIDTH`, 4, bytes per data beat; data width = 8*BYTE_WIDTH; transfer size always full width, no size ports
- `A_WIDTH`, 32, byte-address width
- `DEPTH`, 1024, memory words, any value ≥ 2
- `ID_WIDTH`, 4, transaction ID width
- `sys_clk` in 1 clock, all logic rising-edge
- `sys_rst` in 1 synchronous active-high reset
- `awid` in ID_WIDTH write ID
- `awaddr` in A_WIDTH write start byte address, low log2(BYTE_WIDTH) bits ignored
- `awlen` in 8 beats-1
- `awburst` in 2 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- `awvalid` in 1 / `awready` out 1, AW handshake
- `wdata` in 8*BYTE_WIDTH write data
- `wstrb` in BYTE_WIDTH byte enables, bit n covers `wdata[8n+7:8n]`
- `wlast` in 1 last-beat marker
- `wvalid` in 1 / `wready` out 1, W handshake
- `bid` out ID_WIDTH, equals captured `awid`
- `bresp` out 2, 00 OKAY, 10 SLVERR
- `bvalid` out 1 / `bready` in 1, B handshake
- `arid` in ID_WIDTH read ID
- `araddr` in A_WIDTH read start byte address
- `arlen` in 8 beats-1
- `arburst` in 2 same coding as `awburst`
- `arvalid` in 1 / `arready` out 1, AR handshake
- `rid` out ID_WIDTH, equals captured `arid`
- `rdata` out 8*BYTE_WIDTH read data
- `rresp` out 2, per-beat 00 OKAY, 10 SLVERR
- `rlast` out 1, high on beat arlen+1
- `rvalid` out 1 / `rready` in 1, R handshake

## Operation
- Word index = addr >> log2(BYTE_WIDTH).
- Next index by burst type: FIXED keeps the index; INCR adds 1; WRAP keeps the high bits and increments the low bits modulo (len+1).
- WRAP requires len ∈ {1,3,7,15}. Any other WRAP length, and reserved burst 11, behave as INCR and flag SLVERR.
- Write FSM: W_IDLE (`awready`=1) → W_DATA (`wready`=1) → W_RESP (`bvalid`=1) → W_IDLE on `bready`.
- Each W beat writes the enabled bytes only.
- The burst ends on beat count = awlen+1, regardless of `wlast`. A `wlast` mismatch in either direction sets SLVERR.
- A beat with index ≥ DEPTH is not written and sets SLVERR. `bresp` is the sticky OR of all error flags for the burst.
- Read FSM: R_IDLE (`arready`=1) → R_FETCH (memory read) → R_DATA (`rvalid`=1, data held).
- On an R handshake in R_DATA: go to R_IDLE if the beat was last, otherwise R_FETCH.
- A read beat with index ≥ DEPTH returns `rdata`=0 and `rresp`=10. A burst-type error sets SLVERR on every beat.
- Write and read FSMs are fully independent and may be active simultaneously.
- Same-cycle write and read-fetch of one word returns the old data (read-first).

## Timing
- While `sys_rst`=1: FSMs go to idle, `awready`/`arready`/`wready`/`bvalid`/`rvalid`/`rlast` are 0, and `bid`/`bresp`/`rid`/`rdata`/`rresp` are 0. `awready`/`arready` rise the first cycle after release.
- Reset does not clear memory. Reset mid-burst aborts it without issuing a response; beats already written remain.
- AW handshake at cycle T: `wready` high from T+1, 1 beat/cycle. Last beat at L: `bvalid` at L+1, held until `bready`. `awready` returns the cycle after the B handshake.
- AR handshake at T: first `rvalid` at T+2. Each non-last R handshake at N: next `rvalid` at N+2. Throughput is 1 beat per 2 cycles.
- `rdata`/`rresp`/`rlast`/`rid` are stable while `rvalid`=1 and `rready`=0. `bid`/`bresp` are stable while `bvalid`=1.

## Test plan
- INCR write, addr 0x10, len 3, data 0xA0..A3, strb 0xF, then INCR read of the same range → rdata A0,A1,A2,A3; rlast on beat 4; rresp 00; bresp 00.
- Write 0x11223344 then 0xAABBCCDD with strb 0x5 to the same word → read returns 0x11BB33DD.
- WRAP write, len 3, addr 0x08 (index 2) → beats land at indices 2,3,0,1. WRAP len 2 → bresp 10.
- INCR write, len 1, start index DEPTH-1 → beat 1 written, beat 2 dropped, bresp 10. Read of the same → beat 2 rdata 0 with rresp 10.
- Write burst with `wlast` on beat 2 of len 3 → burst still takes 4 beats, bresp 10. `bready` held low 5 cycles → bvalid/bid stable, `awready` stays 0.
- Concurrent write and read with `rready` toggling, then `sys_rst` pulsed mid-read → all valids drop and both readies return the following cycle.

Source files
------------

// File: rtl/axi4_ram_slave.sv
// axi4_ram_slave: parametrised AXI4 RAM slave with FIXED/INCR/WRAP bursts, byte strobes and SLVERR on bad requests
module axi4_ram_slave #(
  parameter int BYTE_WIDTH = 4,
  parameter int A_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int ID_WIDTH = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [A_WIDTH-1:0]      awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [8*BYTE_WIDTH-1:0] wdata,
  input  logic [BYTE_WIDTH-1:0]   wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [A_WIDTH-1:0]      araddr,
  input  logic [7:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [8*BYTE_WIDTH-1:0] rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int DW = 8*BYTE_WIDTH;
  localparam int OFF = $clog2(BYTE_WIDTH);
  localparam int IW = A_WIDTH - OFF;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] w_idx, r_idx;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic [1:0] w_burst, r_burst;
  logic w_err, r_err, w_fire, w_ok, w_last, w_bad, r_ok, unused_ok;

  function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len);
    return burst == 2'b11 || (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx, input logic [7:0] len, input logic [1:0] burst);
    logic [IW-1:0] mask;
    mask = IW'(len);
    return burst == 2'b00 ? idx : burst == 2'b10 ? (idx & ~mask) | ((idx + IW'(1)) & mask) : idx + IW'(1);
  endfunction

  assign w_fire = wvalid && wready && !sys_rst;
  assign w_ok = w_idx < IW'(DEPTH);
  assign w_last = w_cnt == w_len;
  assign w_bad = w_err || !w_ok || (wlast != w_last);
  assign r_ok = r_idx < IW'(DEPTH);
  assign unused_ok = ^{awaddr, araddr};

  always_ff @(posedge sys_clk)
    if (w_fire && w_ok)
      for (int i = 0; i < BYTE_WIDTH; i++)
        if (wstrb[i]) mem[w_idx[AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bid <= '0;
      bresp <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE:
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready <= 1'b1;
            bid <= awid;
            w_idx <= awaddr[A_WIDTH-1:OFF];
            w_len <= awlen;
            w_cnt <= 8'd0;
            w_burst <= bad_burst(awburst, awlen) ? 2'b01 : awburst;
            w_err <= bad_burst(awburst, awlen);
            w_state <= W_DATA;
          end else awready <= 1'b1;
        W_DATA:
          if (wvalid) begin
            w_cnt <= w_cnt + 8'd1;
            w_idx <= next_idx(w_idx, w_len, w_burst);
            w_err <= w_bad;
            if (w_last) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp <= {w_bad, 1'b0};
              w_state <= W_RESP;
            end
          end
        W_RESP:
          if (bready) begin
            bvalid <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rlast <= 1'b0;
      rid <= '0;
      rdata <= '0;
      rresp <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE:
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid <= arid;
            r_idx <= araddr[A_WIDTH-1:OFF];
            r_len <= arlen;
            r_cnt <= 8'd0;
            r_burst <= bad_burst(arburst, arlen) ? 2'b01 : arburst;
            r_err <= bad_burst(arburst, arlen);
            r_state <= R_FETCH;
          end else arready <= 1'b1;
        R_FETCH: begin
          rdata <= r_ok ? mem[r_idx[AW-1:0]] : '0;
          rresp <= {r_err || !r_ok, 1'b0};
          rlast <= r_cnt == r_len;
          rvalid <= 1'b1;
          r_state <= R_DATA;
        end
        R_DATA:
          if (rready) begin
            rvalid <= 1'b0;
            rlast <= 1'b0;
            if (rlast) begin
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_idx <= next_idx(r_idx, r_len, r_burst);
              r_cnt <= r_cnt + 8'd1;
              r_state <= R_FETCH;
            end
          end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_ram_slave.sv
// tb_axi4_ram_slave: scoreboard bench for axi4_ram_slave
module tb_axi4_ram_slave;
  localparam int DEPTH = 16;
  typedef struct packed {logic [31:0] d; logic [1:0] r; logic l; logic [3:0] id;} beat_t;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [3:0] awid, arid, bid, rid, wstrb;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, arready, rlast, rvalid, rready;
  beat_t exp_r[$], got_r[$];
  logic [1:0] exp_b[$];
  logic [31:0] model [DEPTH];
  logic [31:0] wbuf [16];
  int total = 0, bad = 0;

  always #5 sys_clk = ~sys_clk;

  axi4_ram_slave #(.BYTE_WIDTH(4), .A_WIDTH(32), .DEPTH(DEPTH), .ID_WIDTH(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  function automatic logic berr(input logic [1:0] b, input logic [7:0] len);
    return b == 2'b11 || (b == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
  endfunction

  function automatic int beat_idx(input int start, input int i, input logic [7:0] len, input logic [1:0] b);
    int n;
    n = int'(len) + 1;
    if (berr(b, len) || b == 2'b01) return start + i;
    if (b == 2'b00) return start;
    return start - start % n + (start % n + i) % n;
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] strb, input int wlast_at, input bit do_b,
                           output logic [1:0] resp, output logic [3:0] id_o);
    int g, idx;
    logic err;
    err = berr(burst, len);
    @(negedge sys_clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    g = 0;
    while (!awready && g < 50) begin @(negedge sys_clk); g++; end
    if (!awready) begin total++; bad++; $display("FAIL aw_timeout awready=%b want 1", awready); end
    @(negedge sys_clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      idx = beat_idx(int'(addr >> 2), i, len, burst);
      if (idx < DEPTH) begin
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = wbuf[i][8*b +: 8];
      end else err = 1'b1;
      if ((i == wlast_at) != (i == int'(len))) err = 1'b1;
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wlast = (i == wlast_at);
      g = 0;
      while (!wready && g < 50) begin @(negedge sys_clk); g++; end
      if (!wready) begin total++; bad++; $display("FAIL w_timeout beat=%0d wready=%b want 1", i, wready); end
      @(negedge sys_clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    exp_b.push_back({err, 1'b0});
    if (do_b) begin
      g = 0;
      while (!bvalid && g < 50) begin @(negedge sys_clk); g++; end
      if (!bvalid) begin total++; bad++; $display("FAIL b_timeout bvalid=%b want 1", bvalid); end
      resp = bresp; id_o = bid;
      bready = 1'b1;
      @(negedge sys_clk);
      bready = 1'b0;
    end else begin
      resp = bresp; id_o = bid;
    end
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input bit toggle, input int max_beats, output int lat);
    int g, idx, k, cnt;
    beat_t e;
    for (int i = 0; i <= int'(len); i++) begin
      idx = beat_idx(int'(addr >> 2), i, len, burst);
      e.d = 32'h0;
      if (idx < DEPTH) e.d = model[idx];
      e.r = (berr(burst, len) || idx >= DEPTH) ? 2'b10 : 2'b00;
      e.l = i == int'(len);
      e.id = id;
      exp_r.push_back(e);
    end
    @(negedge sys_clk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    g = 0;
    while (!arready && g < 50) begin @(negedge sys_clk); g++; end
    if (!arready) begin total++; bad++; $display("FAIL ar_timeout arready=%b want 1", arready); end
    @(negedge sys_clk);
    arvalid = 1'b0;
    lat = 0; k = 0; cnt = 1; g = 0;
    while (k < max_beats && g < 200) begin
      rready = toggle ? ~rready : 1'b1;
      if (rvalid && lat == 0) lat = cnt;
      if (rvalid && rready) begin got_r.push_back({rdata, rresp, rlast, rid}); k++; end
      @(negedge sys_clk);
      cnt++; g++;
    end
    rready = 1'b0;
    if (k < max_beats) begin total++; bad++; $display("FAIL r_timeout beats=%0d want %0d", k, max_beats); end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got %b want 000000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    total++;
    if ({bid, bresp, rid, rdata, rresp} !== 44'h0) begin
      bad++; $display("FAIL reset_data got %h want 0", {bid, bresp, rid, rdata, rresp});
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    total++;
    if ({awready, arready} !== 2'b11) begin bad++; $display("FAIL reset_release got %b want 11", {awready, arready}); end
  endtask

  task automatic test_incr();
    logic [1:0] r, eb;
    logic [3:0] io;
    int lat;
    beat_t e, g;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    axi_write(4'd3, 32'h10, 8'd3, 2'b01, 4'hF, 3, 1'b1, r, io);
    eb = exp_b.pop_front();
    total++; if (r !== eb) begin bad++; $display("FAIL incr_bresp got %b want %b", r, eb); end
    total++; if (io !== 4'd3) begin bad++; $display("FAIL incr_bid got %h want 3", io); end
    axi_read(4'd3, 32'h10, 8'd3, 2'b01, 1'b0, 4, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL incr_latency got %0d want 2", lat); end
    while (exp_r.size() > 0 && got_r.size() > 0) begin
      e = exp_r.pop_front(); g = got_r.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL incr_beat got %h want %h", g, e); end
    end
    total++; if (exp_r.size() != got_r.size()) begin bad++; $display("FAIL incr_count got %0d want %0d", got_r.size(), exp_r.size()); end
  endtask

  task automatic test_strb();
    logic [1:0] r, eb;
    logic [3:0] io;
    int lat;
    beat_t e, g;
    wbuf[0] = 32'h11223344;
    axi_write(4'd1, 32'h20, 8'd0, 2'b01, 4'hF, 0, 1'b1, r, io);
    eb = exp_b.pop_front();
    total++; if (r !== eb) begin bad++; $display("FAIL strb_bresp1 got %b want %b", r, eb); end
    wbuf[0] = 32'hAABBCCDD;
    axi_write(4'd1, 32'h20, 8'd0, 2'b01, 4'h5, 0, 1'b1, r, io);
    eb = exp_b.pop_front();
    total++; if (r !== eb) begin bad++; $display("FAIL strb_bresp2 got %b want %b", r, eb); end
    axi_read(4'd2, 32'h20, 8'd0, 2'b01, 1'b0, 1, lat);
    e = exp_r.pop_front(); g = got_r.pop_front();
    total++; if (g !== e) begin bad++; $display("FAIL strb_beat got %h want %h", g, e); end
    total++; if (g.d !== 32'h11BB33DD) begin bad++; $display("FAIL strb_data got %h want 11bb33dd", g.d); end
  endtask

  task automatic test_wrap();
    logic [1:0] r, eb;
    logic [3:0] io;
    int lat;
    beat_t e, g;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + i;
    axi_write(4'd4, 32'h08, 8'd3, 2'b10, 4'hF, 3, 1'b1, r, io);
    eb = exp_b.pop_front();
    total++; if (r !== eb) begin bad++; $display("FAIL wrap_bresp got %b want %b", r, eb); end
    axi_read(4'd4, 32'h00, 8'd3, 2'b01, 1'b0, 4, lat);
    total++; if (got_r.size() > 0 && got_r[0].d !== 32'hB2) begin bad++; $display("FAIL wrap_idx0 got %h want b2", got_r[0].d); end
    axi_read(4'd5, 32'h08, 8'd3, 2'b10, 1'b1, 4, lat);
    while (exp_r.size() > 0 && got_r.size() > 0) begin
      e = exp_r.pop_front(); g = got_r.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL wrap_beat got %h want %h", g, e); end
    end
    total++; if (exp_r.size() != got_r.size()) begin bad++; $display("FAIL wrap_count got %0d want %0d", got_r.size(), exp_r.size()); end
    axi_write(4'd4, 32'h30, 8'd2, 2'b10, 4'hF, 2, 1'b1, r, io);
    eb = exp_b.pop_front();
    total++; if (r !== eb || r !== 2'b10) begin bad++; $display("FAIL wrap_len2_bresp got %b want %b", r, eb); end
  endtask

  task automatic test_oob();
    logic [1:0] r, eb;
    logic [3:0] io;
    int lat;
    beat_t e, g;
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1;
    axi_write(4'd6, 32'h3C, 8'd1, 2'b01, 4'hF, 1, 1'b1, r, io);
    eb = exp_b.pop_front();
    total++; if (r !== eb || r !== 2'b10) begin bad++; $display("FAIL oob_bresp got %b want %b", r, eb); end
    axi_read(4'd6, 32'h3C, 8'd1, 2'b01, 1'b0, 2, lat);
    total++; if (got_r.size() > 1 && {got_r[1].d, got_r[1].r} !== {32'h0, 2'b10}) begin
      bad++; $display("FAIL oob_beat2 got %h want 0/10", {got_r[1].d, got_r[1].r});
    end
    axi_read(4'd7, 32'h10, 8'd1, 2'b11, 1'b0, 2, lat);
    while (exp_r.size() > 0 && got_r.size() > 0) begin
      e = exp_r.pop_front(); g = got_r.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL oob_beat got %h want %h", g, e); end
    end
    total++; if (exp_r.size() != got_r.size()) begin bad++; $display("FAIL oob_count got %0d want %0d", got_r.size(), exp_r.size()); end
  endtask

  task automatic test_wlast();
    logic [1:0] r, eb;
    logic [3:0] io;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hD0 + i;
    axi_write(4'd8, 32'h24, 8'd3, 2'b01, 4'hF, 1, 1'b0, r, io);
    eb = exp_b.pop_front();
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({bvalid, bid, bresp, awready} !== {1'b1, 4'd8, eb, 1'b0}) begin
        bad++; $display("FAIL wlast_hold cycle=%0d got %b want %b", c, {bvalid, bid, bresp, awready}, {1'b1, 4'd8, eb, 1'b0});
      end
      @(negedge sys_clk);
    end
    bready = 1'b1;
    @(negedge sys_clk);
    bready = 1'b0;
    total++; if ({bvalid, awready} !== 2'b01) begin bad++; $display("FAIL wlast_release got %b want 01", {bvalid, awready}); end
  endtask

  task automatic test_concurrent();
    logic [1:0] r, eb;
    logic [3:0] io;
    int lat;
    beat_t e, g;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hE0 + i;
    fork
      axi_write(4'd9, 32'h28, 8'd3, 2'b01, 4'hF, 3, 1'b1, r, io);
      axi_read(4'd5, 32'h10, 8'd3, 2'b01, 1'b1, 4, lat);
    join
    eb = exp_b.pop_front();
    total++; if ({r, io} !== {eb, 4'd9}) begin bad++; $display("FAIL conc_b got %h want %h", {r, io}, {eb, 4'd9}); end
    total++; if (lat !== 2) begin bad++; $display("FAIL conc_latency got %0d want 2", lat); end
    axi_read(4'd2, 32'h10, 8'd7, 2'b01, 1'b0, 2, lat);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    total++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
      bad++; $display("FAIL midrst_ctrl got %b want 000000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    total++; if ({awready, arready, rvalid} !== 3'b110) begin bad++; $display("FAIL midrst_release got %b want 110", {awready, arready, rvalid}); end
    while (got_r.size() > 0) begin
      e = exp_r.pop_front(); g = got_r.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL conc_beat got %h want %h", g, e); end
    end
    exp_r.delete();
    axi_read(4'd3, 32'h10, 8'd3, 2'b01, 1'b0, 4, lat);
    while (exp_r.size() > 0 && got_r.size() > 0) begin
      e = exp_r.pop_front(); g = got_r.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL retain_beat got %h want %h", g, e); end
    end
    total++; if (exp_r.size() != got_r.size()) begin bad++; $display("FAIL retain_count got %0d want %0d", got_r.size(), exp_r.size()); end
  endtask

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    test_reset();
    test_incr();
    test_strb();
    test_wrap();
    test_oob();
    test_wlast();
    test_concurrent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
